// File: rtl/stochround_pipe_if.sv
// Streaming handshake bundle for stochround_pipe: an input sample channel
// (valid/ready, packed lanes, rounding mode) and an output result channel
// (valid/ready, packed rounded lanes, per-lane saturation flags).
interface stochround_pipe_if #(
    parameter int N_CH  = 4,
    parameter int IN_W  = 24,
    parameter int OUT_W = 16
) ();
    logic                    in_valid;
    logic                    in_ready;
    logic [N_CH*IN_W-1:0]    in_data;
    logic [1:0]              in_mode;
    logic                    out_valid;
    logic                    out_ready;
    logic [N_CH*OUT_W-1:0]   out_data;
    logic [N_CH-1:0]         out_sat;

    // Producer / consumer side of the bus (drives samples, accepts results).
    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    // Rounding engine side of the bus.
    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/stochround_pipe.sv
// stochround_pipe: N_CH parallel lanes that narrow IN_W-bit signed samples
// to OUT_W bits with stochastic, round-half-up or truncating rounding.
// Each lane owns a Galois LFSR whose low D bits form the stochastic addend.
// Stage 1 holds the shifted (pre-saturation) quotient, stage 2 holds the
// clamped result and saturation flags that drive the outputs.
module stochround_pipe #(
    parameter int                N_CH     = 4,
    parameter int                IN_W     = 24,
    parameter int                OUT_W    = 16,
    parameter int                LFSR_W   = 15,
    parameter logic [LFSR_W-1:0] TAPS     = 15'h6000,
    parameter logic [LFSR_W-1:0] RST_SEED = 15'h0001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog,
    input  logic [LFSR_W-1:0] seed,
    stochround_pipe_if.slave  bus,
    output logic [LFSR_W-1:0] lfsr_dbg
);

    // Number of discarded fraction bits.
    localparam int D     = IN_W - OUT_W;
    // Sign-extended sum width (one guard bit so the addend never wraps).
    localparam int SUM_W = IN_W + 1;
    // Quotient width after dropping D bits; one bit wider than the output.
    localparam int Q_W   = OUT_W + 1;

    // Round-half-up addend: one half of an output LSB.
    localparam logic [SUM_W-1:0] HALF_ADD = {{(SUM_W-1){1'b0}}, 1'b1} << (D - 1);

    // Lane seed: base XOR lane index, with the LFSR lock-up state avoided.
    function automatic logic [LFSR_W-1:0] lane_seed(input logic [LFSR_W-1:0] base,
                                                    input int unsigned       lane);
        logic [LFSR_W-1:0] v;
        v = base ^ LFSR_W'(lane);
        if (v == {LFSR_W{1'b0}}) begin
            v = {{(LFSR_W-1){1'b0}}, 1'b1};
        end else begin
            v = v;
        end
        return v;
    endfunction

    // One right-shift Galois step.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : {LFSR_W{1'b0}});
    endfunction

    // Sign-extend, add the rounding addend and drop the fraction bits.
    // The logical shift is sufficient because only the low Q_W bits survive.
    function automatic logic [Q_W-1:0] round_q(input logic [IN_W-1:0]  x,
                                               input logic [SUM_W-1:0] addend);
        logic [SUM_W-1:0] sum;
        sum = {x[IN_W-1], x} + addend;
        return Q_W'(sum >> D);
    endfunction

    // Clamp a Q_W-bit quotient into OUT_W bits; returns {sat, value}.
    // Overflow shows up as disagreement between the two top quotient bits.
    function automatic logic [OUT_W:0] saturate(input logic [Q_W-1:0] q);
        logic [OUT_W:0] r;
        if (q[Q_W-1] == q[Q_W-2]) begin
            r = {1'b0, q[OUT_W-1:0]};
        end else if (q[Q_W-1] == 1'b0) begin
            r = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            r = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
        end
        return r;
    endfunction

    logic [LFSR_W-1:0]     lfsr_r   [N_CH];
    logic [SUM_W-1:0]      addend_s [N_CH];
    logic [Q_W-1:0]        q_s      [N_CH];
    logic [Q_W-1:0]        s1_q_r   [N_CH];
    logic [OUT_W:0]        sat_s    [N_CH];
    logic                  s1_v_r;
    logic                  s2_v_r;
    logic [N_CH*OUT_W-1:0] out_data_r;
    logic [N_CH-1:0]       out_sat_r;
    logic                  en1_s;
    logic                  en2_s;
    logic                  ready_s;
    logic                  accept_s;

    // Stage enables and input acceptance; prog blocks new samples only.
    always_comb begin
        en2_s    = 1'b0;
        en1_s    = 1'b0;
        ready_s  = 1'b0;
        accept_s = 1'b0;
        en2_s    = !s2_v_r || bus.out_ready;
        en1_s    = !s1_v_r || en2_s;
        ready_s  = en1_s && !prog;
        accept_s = bus.in_valid && ready_s;
    end

    // Per-lane addend selection and quotient for the incoming sample.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            addend_s[i] = {SUM_W{1'b0}};
            case (bus.in_mode)
                2'd0:    addend_s[i] = {{(SUM_W-D){1'b0}}, lfsr_r[i][D-1:0]};
                2'd1:    addend_s[i] = HALF_ADD;
                2'd2:    addend_s[i] = {SUM_W{1'b0}};
                2'd3:    addend_s[i] = {SUM_W{1'b0}};
                default: addend_s[i] = {SUM_W{1'b0}};
            endcase
            q_s[i] = round_q(bus.in_data[i*IN_W +: IN_W], addend_s[i]);
        end
    end

    // Saturation of the stage-1 quotients feeding stage 2.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            sat_s[i] = saturate(s1_q_r[i]);
        end
    end

    // Lane LFSRs: reset seed, then programmed seed, then one step per accept.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (rst) begin
                lfsr_r[i] <= lane_seed(RST_SEED, i);
            end else if (prog) begin
                lfsr_r[i] <= lane_seed(seed, i);
            end else if (accept_s) begin
                lfsr_r[i] <= lfsr_step(lfsr_r[i]);
            end else begin
                lfsr_r[i] <= lfsr_r[i];
            end
        end
    end

    // Stage 1: capture the quotient of each accepted sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_r <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                s1_q_r[i] <= {Q_W{1'b0}};
            end
        end else if (en1_s) begin
            s1_v_r <= accept_s;
            if (accept_s) begin
                for (int i = 0; i < N_CH; i++) begin
                    s1_q_r[i] <= q_s[i];
                end
            end
        end
    end

    // Stage 2: registered saturated result; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v_r     <= 1'b0;
            out_data_r <= {(N_CH*OUT_W){1'b0}};
            out_sat_r  <= {N_CH{1'b0}};
        end else if (en2_s) begin
            s2_v_r <= s1_v_r;
            if (s1_v_r) begin
                for (int i = 0; i < N_CH; i++) begin
                    out_data_r[i*OUT_W +: OUT_W] <= sat_s[i][OUT_W-1:0];
                    out_sat_r[i]                 <= sat_s[i][OUT_W];
                end
            end
        end
    end

    assign bus.in_ready  = ready_s;
    assign bus.out_valid = s2_v_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_sat   = out_sat_r;
    assign lfsr_dbg      = lfsr_r[0];

endmodule

// File: tb/tb_stochround_pipe.sv
// Self-checking bench for stochround_pipe: directed table of deterministic
// rounding vectors, LFSR sequence/period, stochastic statistics, random
// backpressure against a scoreboard, prog during drain and mid-stream reset.
module tb_stochround_pipe;
    localparam int N_CH   = 4;
    localparam int IN_W   = 24;
    localparam int OUT_W  = 16;
    localparam int LFSR_W = 15;
    localparam int D      = IN_W - OUT_W;
    localparam logic [LFSR_W-1:0] TAPS     = 15'h6000;
    localparam logic [LFSR_W-1:0] RST_SEED = 15'h0001;
    localparam longint MAXV = (longint'(1) << (OUT_W - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (OUT_W - 1));

    logic              clk = 1'b0;
    logic              rst;
    logic              prog;
    logic [LFSR_W-1:0] seed;
    logic [LFSR_W-1:0] lfsr_dbg;

    stochround_pipe_if #(.N_CH(N_CH), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    stochround_pipe #(
        .N_CH(N_CH), .IN_W(IN_W), .OUT_W(OUT_W), .LFSR_W(LFSR_W),
        .TAPS(TAPS), .RST_SEED(RST_SEED)
    ) dut (
        .clk(clk), .rst(rst), .prog(prog), .seed(seed),
        .bus(bus), .lfsr_dbg(lfsr_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N_CH*OUT_W-1:0] data;
        logic [N_CH-1:0]       sat;
    } exp_t;

    typedef struct {
        logic [1:0]       mode;
        logic [IN_W-1:0]  x;
        logic [OUT_W-1:0] y;
        logic             sat;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    logic [LFSR_W-1:0] m_lfsr [N_CH];
    bit   bp_en   = 1'b0;
    bit   stoch_en = 1'b0;
    int   xfer_cnt = 0;
    int   cnt1 = 0;
    int   cnt_other = 0;
    logic [N_CH*OUT_W-1:0] last_data;
    logic [N_CH-1:0]       last_sat;
    bit   prev_stall = 1'b0;
    logic [N_CH*OUT_W-1:0] prev_data;
    logic [N_CH-1:0]       prev_sat;
    exp_t mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic err(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s @%0t: timeout", name, $time);
    endtask

    function automatic logic [LFSR_W-1:0] m_step(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : 15'h0000);
    endfunction

    function automatic logic [LFSR_W-1:0] m_seed(input logic [LFSR_W-1:0] base, input int i);
        logic [LFSR_W-1:0] v;
        v = base ^ LFSR_W'(i);
        if (v == 15'h0000) v = 15'h0001;
        return v;
    endfunction

    // Integer reference of one lane: returns {sat, value}.
    function automatic logic [OUT_W:0] ref_lane(input logic [IN_W-1:0] x, input logic [1:0] mode,
                                                input logic [LFSR_W-1:0] s);
        longint xi, add, q;
        logic [OUT_W:0] r;
        xi = longint'($signed(x));
        case (mode)
            2'd0:    add = longint'(s) % (longint'(1) << D);
            2'd1:    add = longint'(1) << (D - 1);
            default: add = 0;
        endcase
        q = (xi + add) >>> D;
        if (q > MAXV)      r = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
        else if (q < MINV) r = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
        else               r = {1'b0, q[OUT_W-1:0]};
        return r;
    endfunction

    task automatic model_reset(input logic [LFSR_W-1:0] base);
        for (int i = 0; i < N_CH; i++) m_lfsr[i] = m_seed(base, i);
    endtask

    task automatic model_accept(input logic [N_CH*IN_W-1:0] d, input logic [1:0] m);
        exp_t e;
        logic [OUT_W:0] r;
        for (int i = 0; i < N_CH; i++) begin
            r = ref_lane(d[i*IN_W +: IN_W], m, m_lfsr[i]);
            e.data[i*OUT_W +: OUT_W] = r[OUT_W-1:0];
            e.sat[i] = r[OUT_W];
            m_lfsr[i] = m_step(m_lfsr[i]);
        end
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_en) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    // Offer one sample until accepted; returns 1 ns after the accepting edge.
    task automatic send(input logic [N_CH*IN_W-1:0] d, input logic [1:0] m);
        bit done = 1'b0;
        int w = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_mode  = m;
        while (!done) begin
            #1;
            if (bus.in_ready) begin
                model_accept(d, m);
                done = 1'b1;
            end else begin
                w++;
                if (w > 100) begin
                    err("send_accept");
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            if (bp_en) bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            tick();
            w++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [N_CH*IN_W-1:0] rep_in(input logic [IN_W-1:0] x);
        return {N_CH{x}};
    endfunction

    // Output monitor: scoreboard, stall-hold check and stochastic counting.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(bus.out_valid), 64'd1);
                check("hold_data", 64'(bus.out_data), 64'(prev_data));
                check("hold_sat", 64'(bus.out_sat), 64'(prev_sat));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    err("unexpected_output");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_data", 64'(bus.out_data), 64'(mon_e.data));
                    check("sb_sat", 64'(bus.out_sat), 64'(mon_e.sat));
                end
                last_data = bus.out_data;
                last_sat  = bus.out_sat;
                xfer_cnt++;
                if (stoch_en) begin
                    if (bus.out_data[OUT_W-1:0] == 16'h0001) cnt1++;
                    for (int i = 0; i < N_CH; i++) begin
                        if (bus.out_data[i*OUT_W +: OUT_W] != 16'h0000 &&
                            bus.out_data[i*OUT_W +: OUT_W] != 16'h0001) cnt_other++;
                    end
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_sat   = bus.out_sat;
        end
    end

    vec_t tbl [13];

    initial begin
        int first_ret;
        int c0;
        int w;
        logic [N_CH*IN_W-1:0] rd;

        // mode, x, expected out, expected sat (hand-computed, D = 8)
        tbl[0]  = '{2'd1, 24'h000180, 16'h0002, 1'b0};
        tbl[1]  = '{2'd2, 24'h0001FF, 16'h0001, 1'b0};
        tbl[2]  = '{2'd2, 24'hFFFFFF, 16'hFFFF, 1'b0};
        tbl[3]  = '{2'd1, 24'h7FFFFF, 16'h7FFF, 1'b1};
        tbl[4]  = '{2'd1, 24'h800000, 16'h8000, 1'b0};
        tbl[5]  = '{2'd3, 24'h0001FF, 16'h0001, 1'b0};
        tbl[6]  = '{2'd1, 24'h00017F, 16'h0001, 1'b0};
        tbl[7]  = '{2'd2, 24'h800000, 16'h8000, 1'b0};
        tbl[8]  = '{2'd2, 24'h7FFFFF, 16'h7FFF, 1'b0};
        tbl[9]  = '{2'd1, 24'hFFFF80, 16'h0000, 1'b0};
        tbl[10] = '{2'd1, 24'hFFFF7F, 16'hFFFF, 1'b0};
        tbl[11] = '{2'd1, 24'h7FFF7F, 16'h7FFF, 1'b0};
        tbl[12] = '{2'd1, 24'h7FFF80, 16'h7FFF, 1'b1};

        rst = 1'b1; prog = 1'b0; seed = 15'h0000;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_mode = 2'd0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset(RST_SEED);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_sat", 64'(bus.out_sat), 64'd0);
        check("rst_lfsr", 64'(lfsr_dbg), 64'h0001);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // prog with seed 0 while a sample is offered: nothing is accepted.
        prog = 1'b1; seed = 15'h0000; bus.in_valid = 1'b1; bus.in_data = rep_in(24'h000100);
        #1;
        check("prog_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        prog = 1'b0; bus.in_valid = 1'b0;
        model_reset(15'h0000);
        check("prog_lfsr", 64'(lfsr_dbg), 64'h0001);
        tick();
        tick();
        check("prog_no_accept", 64'(bus.out_valid), 64'd0);

        send('0, 2'd2);
        check("lfsr_step1", 64'(lfsr_dbg), 64'h6000);
        send('0, 2'd2);
        check("lfsr_step2", 64'(lfsr_dbg), 64'h3000);
        first_ret = 0;
        for (int j = 3; j <= 32767; j++) begin
            send('0, 2'd2);
            if (first_ret == 0 && lfsr_dbg == 15'h0001) first_ret = j;
        end
        check("lfsr_period", 64'(first_ret), 64'd32767);
        drain();

        // Directed deterministic vectors.
        for (int i = 0; i < 13; i++) begin
            c0 = xfer_cnt;
            send(rep_in(tbl[i].x), tbl[i].mode);
            if (i == 0) begin
                check("latency_s1_only", 64'(bus.out_valid), 64'd0);
                tick();
                check("latency_out_valid", 64'(bus.out_valid), 64'd1);
            end
            w = 0;
            while (xfer_cnt == c0 && w < 20) begin
                tick();
                w++;
            end
            if (xfer_cnt == c0) err($sformatf("vec%0d_wait", i));
            check($sformatf("vec%0d_data", i), 64'(last_data), 64'({N_CH{tbl[i].y}}));
            check($sformatf("vec%0d_sat", i), 64'(last_sat), 64'({N_CH{tbl[i].sat}}));
        end
        drain();

        // Stochastic statistics for x = 0x40: lane 0 should give 1 a quarter of the time.
        prog = 1'b1; seed = 15'h2A5F;
        tick();
        prog = 1'b0;
        model_reset(15'h2A5F);
        stoch_en = 1'b1;
        for (int j = 0; j < 4096; j++) send(rep_in(24'h000040), 2'd0);
        drain();
        stoch_en = 1'b0;
        n_checks++;
        if (cnt1 < 973 || cnt1 > 1075) begin
            n_fail++;
            $display("FAIL stoch_count: got %0d ones, expected 1024 +/- 51", cnt1);
        end
        check("stoch_other", 64'(cnt_other), 64'd0);

        // prog while two samples are in flight; they keep their original rnd.
        bus.out_ready = 1'b0;
        send(rep_in(24'h0012C3), 2'd0);
        send(rep_in(24'hFF80A7), 2'd0);
        prog = 1'b1; seed = 15'h5555; bus.out_ready = 1'b1;
        tick();
        prog = 1'b0;
        model_reset(15'h5555);
        check("prog_drain_lfsr", 64'(lfsr_dbg), 64'h5555);
        drain();

        // Random backpressure with random data and modes.
        c0 = xfer_cnt;
        bp_en = 1'b1;
        for (int j = 0; j < 1000; j++) begin
            for (int i = 0; i < N_CH; i++) rd[i*IN_W +: IN_W] = IN_W'($urandom);
            send(rd, 2'($urandom_range(0, 3)));
        end
        drain();
        bp_en = 1'b0;
        bus.out_ready = 1'b1;
        check("bp_count", 64'(xfer_cnt - c0), 64'd1000);

        // Reset with two samples in flight; rst also beats prog and acceptance.
        bus.out_ready = 1'b0;
        send(rep_in(24'h123456), 2'd1);
        send(rep_in(24'h654321), 2'd1);
        rst = 1'b1; prog = 1'b1; seed = 15'h7777;
        bus.in_valid = 1'b1; bus.in_data = rep_in(24'h000100);
        tick();
        rst = 1'b0; prog = 1'b0; bus.in_valid = 1'b0;
        exp_q.delete();
        model_reset(RST_SEED);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_lfsr", 64'(lfsr_dbg), 64'(RST_SEED));
        tick();
        check("midrst_out_valid2", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;
        send(rep_in(24'h0003A1), 2'd0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
